// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. Owns the fetch PC and issues word requests to
//   instruction memory (req/gnt, in-order rvalid responses). Returned words are
//   buffered with their PCs in a small FIFO and presented to decode over a
//   valid/ready handshake. A redirect flushes the FIFO, marks every in-flight
//   response as stale and restarts fetch at the (word-aligned) target.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   o_imem_req, o_imem_addr      fetch request and byte address
//   i_imem_gnt                   request accepted when high with o_imem_req
//   i_imem_rvalid, i_imem_rdata  in-order response
//   i_redirect, i_redirect_pc    redirect request and target
//   o_valid, i_ready             decode handshake
//   o_inst, o_pc                 FIFO head (NOP_INST / fetch PC when empty)
//   o_misaligned                 pulse after a redirect to a non-word target

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   output logic        o_misaligned
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [31:0]   r_fetch_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_drop;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_pq_rd;
   logic [AW-1:0] r_pq_wr;
   logic          r_misaligned;

   logic [31:0]   r_fifo_inst [DEPTH];
   logic [31:0]   r_fifo_pc   [DEPTH];
   logic [31:0]   r_pq        [DEPTH];

   logic          w_credit_ok;
   logic          w_grant;
   logic          w_resp;
   logic          w_push;
   logic          w_pop;
   logic          w_nonempty;
   logic [CW-1:0] w_out_next;
   logic [CW-1:0] w_drop_next;
   logic [CW-1:0] w_count_next;

   // Credit counts both in-flight requests and buffered entries, so a
   // response always finds a free FIFO slot even when decode stalls.
   assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_C;
   assign o_imem_req  = !i_rst && !i_redirect && w_credit_ok;
   assign o_imem_addr = r_fetch_pc;
   assign w_grant     = o_imem_req && i_imem_gnt;

   // Responses with nothing outstanding belong to requests issued before a
   // reset and are ignored.
   assign w_resp      = i_imem_rvalid && (r_outstanding != '0);
   assign w_push      = w_resp && !i_redirect && (r_drop == '0);

   assign w_nonempty  = (r_count != '0);
   assign o_valid     = w_nonempty && !i_redirect && !i_rst;
   assign w_pop       = o_valid && i_ready;
   assign o_inst      = (w_nonempty && !i_rst) ? r_fifo_inst[r_rd_ptr] : NOP_INST;
   assign o_pc        = w_nonempty ? r_fifo_pc[r_rd_ptr] : r_fetch_pc;
   assign o_misaligned = r_misaligned;

   always_comb begin
      w_out_next   = r_outstanding + CW'(w_grant) - CW'(w_resp);
      w_drop_next  = r_drop;
      w_count_next = r_count;
      if (i_redirect) begin
         // Everything still in flight is stale, including anything that
         // did not respond this cycle; no grant is possible here.
         w_drop_next  = w_out_next;
         w_count_next = '0;
      end else begin
         if (w_resp && (r_drop != '0)) begin
            w_drop_next = r_drop - 1'b1;
         end
         w_count_next = r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= '0;
         r_drop        <= '0;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_pq_rd       <= '0;
         r_pq_wr       <= '0;
         r_misaligned  <= 1'b0;
      end else begin
         r_outstanding <= w_out_next;
         r_drop        <= w_drop_next;
         r_count       <= w_count_next;
         r_misaligned  <= i_redirect && (i_redirect_pc[1:0] != 2'b00);

         // The pc queue tracks every in-flight request, stale or not, so its
         // pointers survive a redirect.
         if (w_grant) begin
            r_pq_wr <= r_pq_wr + 1'b1;
         end
         if (w_resp) begin
            r_pq_rd <= r_pq_rd + 1'b1;
         end

         if (i_redirect) begin
            r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
         end else begin
            if (w_grant) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_grant) begin
         r_pq[r_pq_wr] <= r_fetch_pc;
      end
      if (w_push) begin
         r_fifo_inst[r_wr_ptr] <= i_imem_rdata;
         r_fifo_pc[r_wr_ptr]   <= r_pq[r_pq_rd];
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A small in-order memory model answers grants
// after a programmable latency with data = addr ^ 32'hDEAD_0000. Inputs change
// on the falling edge; outputs are sampled 1 time unit later.

module tb_fetch_unit;

   localparam int DEPTH = 2;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_inst;
   logic [31:0] o_pc;
   logic        o_misaligned;

   int asserts = 0;
   int fails   = 0;
   int cyc     = 0;
   int lat     = 1;

   logic [31:0] mq_addr [$];
   int          mq_due  [$];
   logic [31:0] gq      [$];
   logic [31:0] dq_pc   [$];
   logic [31:0] dq_inst [$];

   logic        obs_req, obs_valid, obs_mis, obs_hs;
   logic [31:0] obs_addr, obs_pc, obs_inst;

   fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
      .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
      .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst), .o_pc(o_pc),
      .o_misaligned(o_misaligned)
   );

   always #5 clk = ~clk;

   // One clock cycle: drive memory response, sample, record, advance.
   task automatic cycle();
      if (i_rst) begin
         mq_addr.delete();
         mq_due.delete();
      end
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'h0;
      if (mq_addr.size() > 0 && mq_due[0] == cyc) begin
         i_imem_rvalid = 1'b1;
         i_imem_rdata  = mq_addr[0] ^ 32'hDEAD_0000;
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      #1;
      obs_req   = o_imem_req;
      obs_addr  = o_imem_addr;
      obs_valid = o_valid;
      obs_pc    = o_pc;
      obs_inst  = o_inst;
      obs_mis   = o_misaligned;
      obs_hs    = o_imem_req && i_imem_gnt;
      if (obs_hs) begin
         mq_addr.push_back(o_imem_addr);
         mq_due.push_back(cyc + lat);
         gq.push_back(o_imem_addr);
      end
      if (o_valid && i_ready) begin
         dq_pc.push_back(o_pc);
         dq_inst.push_back(o_inst);
      end
      if (i_imem_rvalid && !i_redirect && !i_rst && dut.r_drop == '0) begin
         asserts++;
         if (dut.r_count == DEPTH[2:0] && !(o_valid && i_ready)) begin
            fails++;
            $display("FAIL fifo_overflow: push into full FIFO at cycle %0d", cyc);
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_logs();
      gq.delete();
      dq_pc.delete();
      dq_inst.delete();
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_redirect = 1'b0;
      cycle();
      cycle();
      i_rst = 1'b0;
      clear_logs();
   endtask

   task automatic run_until_dq(input int n, input int budget, input string name);
      int k = 0;
      while (dq_pc.size() < n && k < budget) begin
         cycle();
         k++;
      end
      asserts++;
      if (dq_pc.size() < n) begin
         fails++;
         $display("FAIL %s_timeout: delivered %0d required %0d", name, dq_pc.size(), n);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = 32'h0;
      i_imem_gnt = 1'b1; i_ready = 1'b1; lat = 1;
      cycle();
      asserts++; if (obs_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b expected 0", obs_req); end
      asserts++; if (obs_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", obs_valid); end
      asserts++; if (obs_inst !== NOP) begin fails++; $display("FAIL rst_inst: got %h expected %h", obs_inst, NOP); end
      cycle();
      asserts++; if (obs_mis !== 1'b0) begin fails++; $display("FAIL rst_mis: got %b expected 0", obs_mis); end
      i_rst = 1'b0;
      clear_logs();
      cycle();
      asserts++; if (obs_req !== 1'b1) begin fails++; $display("FAIL rel_req: got %b expected 1", obs_req); end
      asserts++; if (obs_addr !== 32'h0) begin fails++; $display("FAIL rel_addr: got %h expected 00000000", obs_addr); end
      asserts++; if (obs_valid !== 1'b0) begin fails++; $display("FAIL rel_valid: got %b expected 0", obs_valid); end
   endtask

   task automatic test_stream();
      int g_cyc = -1;
      int v_cyc = -1;
      int k = 0;
      do_reset();
      i_imem_gnt = 1'b1; i_ready = 1'b1; lat = 1;
      while (dq_pc.size() < 6 && k < 40) begin
         cycle();
         if (obs_hs && g_cyc < 0) g_cyc = cyc;
         if (obs_valid && v_cyc < 0) v_cyc = cyc;
         k++;
      end
      asserts++;
      if (dq_pc.size() < 6) begin
         fails++; $display("FAIL stream_timeout: delivered %0d required 6", dq_pc.size());
         return;
      end
      asserts++; if (gq[0] !== 32'h0) begin fails++; $display("FAIL stream_first_addr: got %h expected 00000000", gq[0]); end
      asserts++; if (v_cyc - g_cyc != 2) begin fails++; $display("FAIL stream_latency: got %0d expected 2", v_cyc - g_cyc); end
      for (int i = 0; i < 6; i++) begin
         asserts++;
         if (dq_pc[i] !== 32'(i * 4)) begin fails++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, dq_pc[i], 32'(i * 4)); end
         asserts++;
         if (dq_inst[i] !== (32'hDEAD_0000 + 32'(i * 4))) begin
            fails++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, dq_inst[i], 32'hDEAD_0000 + 32'(i * 4));
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      i_imem_gnt = 1'b1; i_ready = 1'b0; lat = 1;
      repeat (10) cycle();
      asserts++; if (gq.size() != 2) begin fails++; $display("FAIL bp_grants: got %0d expected 2", gq.size()); end
      asserts++; if (obs_req !== 1'b0) begin fails++; $display("FAIL bp_req: got %b expected 0", obs_req); end
      asserts++; if (obs_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b expected 1", obs_valid); end
      asserts++; if (obs_pc !== 32'h0) begin fails++; $display("FAIL bp_head_pc: got %h expected 00000000", obs_pc); end
      asserts++; if (obs_inst !== 32'hDEAD_0000) begin fails++; $display("FAIL bp_head_inst: got %h expected dead0000", obs_inst); end
      i_ready = 1'b1;
      run_until_dq(3, 20, "bp");
      if (dq_pc.size() < 3 || gq.size() < 3) return;
      asserts++; if (dq_pc[0] !== 32'h0) begin fails++; $display("FAIL bp_pc0: got %h expected 00000000", dq_pc[0]); end
      asserts++; if (dq_pc[1] !== 32'h4) begin fails++; $display("FAIL bp_pc1: got %h expected 00000004", dq_pc[1]); end
      asserts++; if (dq_pc[2] !== 32'h8) begin fails++; $display("FAIL bp_pc2: got %h expected 00000008", dq_pc[2]); end
      asserts++; if (dq_inst[1] !== 32'hDEAD_0004) begin fails++; $display("FAIL bp_inst1: got %h expected dead0004", dq_inst[1]); end
      asserts++; if (gq[2] !== 32'h8) begin fails++; $display("FAIL bp_resume_addr: got %h expected 00000008", gq[2]); end
   endtask

   task automatic test_redirect_stale();
      int k = 0;
      int gi;
      bit stale = 0;
      do_reset();
      i_imem_gnt = 1'b1; i_ready = 1'b1; lat = 3;
      run_until_dq(2, 20, "rd_pre");
      while (mq_addr.size() < 2 && k < 10) begin cycle(); k++; end
      asserts++; if (mq_addr.size() != 2) begin fails++; $display("FAIL rd_inflight: got %0d expected 2", mq_addr.size()); end
      gi = gq.size();
      i_redirect = 1'b1; i_redirect_pc = 32'h100;
      cycle();
      asserts++; if (obs_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_forced: got %b expected 0", obs_valid); end
      asserts++; if (obs_req !== 1'b0) begin fails++; $display("FAIL rd_req_forced: got %b expected 0", obs_req); end
      i_redirect = 1'b0;
      run_until_dq(4, 40, "rd_post");
      if (dq_pc.size() < 4) return;
      for (int i = 0; i < dq_pc.size(); i++)
         if (dq_pc[i] == 32'h8 || dq_pc[i] == 32'hC) stale = 1;
      asserts++; if (stale) begin fails++; $display("FAIL rd_stale_visible: got stale pc expected none"); end
      asserts++; if (gq[gi] !== 32'h100) begin fails++; $display("FAIL rd_first_addr: got %h expected 00000100", gq[gi]); end
      asserts++; if (dq_pc[2] !== 32'h100) begin fails++; $display("FAIL rd_first_pc: got %h expected 00000100", dq_pc[2]); end
      asserts++; if (dq_inst[2] !== 32'hDEAD_0100) begin fails++; $display("FAIL rd_first_inst: got %h expected dead0100", dq_inst[2]); end
      asserts++; if (dq_pc[3] !== 32'h104) begin fails++; $display("FAIL rd_second_pc: got %h expected 00000104", dq_pc[3]); end
   endtask

   task automatic test_misaligned();
      int gi, di;
      int k = 0;
      do_reset();
      i_imem_gnt = 1'b1; i_ready = 1'b1; lat = 1;
      repeat (3) cycle();
      gi = gq.size(); di = dq_pc.size();
      i_redirect = 1'b1; i_redirect_pc = 32'h103;
      cycle();
      asserts++; if (obs_mis !== 1'b0) begin fails++; $display("FAIL mis_before: got %b expected 0", obs_mis); end
      i_redirect = 1'b0;
      cycle();
      asserts++; if (obs_mis !== 1'b1) begin fails++; $display("FAIL mis_pulse: got %b expected 1", obs_mis); end
      cycle();
      asserts++; if (obs_mis !== 1'b0) begin fails++; $display("FAIL mis_once: got %b expected 0", obs_mis); end
      while (dq_pc.size() <= di && k < 20) begin cycle(); k++; end
      asserts++;
      if (gq.size() <= gi || dq_pc.size() <= di) begin fails++; $display("FAIL mis_timeout: no fetch after redirect"); return; end
      asserts++; if (gq[gi] !== 32'h100) begin fails++; $display("FAIL mis_addr: got %h expected 00000100", gq[gi]); end
      asserts++; if (dq_pc[di] !== 32'h100) begin fails++; $display("FAIL mis_pc: got %h expected 00000100", dq_pc[di]); end
   endtask

   task automatic test_wrap();
      int gi, di;
      int k = 0;
      do_reset();
      i_imem_gnt = 1'b1; i_ready = 1'b1; lat = 1;
      repeat (3) cycle();
      gi = gq.size(); di = dq_pc.size();
      i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
      cycle();
      i_redirect = 1'b0;
      while (dq_pc.size() < di + 2 && k < 20) begin cycle(); k++; end
      asserts++;
      if (dq_pc.size() < di + 2) begin fails++; $display("FAIL wrap_timeout: delivered %0d", dq_pc.size() - di); return; end
      asserts++; if (gq[gi] !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr0: got %h expected fffffffc", gq[gi]); end
      asserts++; if (gq[gi+1] !== 32'h0) begin fails++; $display("FAIL wrap_addr1: got %h expected 00000000", gq[gi+1]); end
      asserts++; if (dq_pc[di] !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc0: got %h expected fffffffc", dq_pc[di]); end
      asserts++; if (dq_inst[di] !== 32'h2152_FFFC) begin fails++; $display("FAIL wrap_inst0: got %h expected 2152fffc", dq_inst[di]); end
      asserts++; if (dq_pc[di+1] !== 32'h0) begin fails++; $display("FAIL wrap_pc1: got %h expected 00000000", dq_pc[di+1]); end
   endtask

   task automatic test_back_to_back();
      int gi;
      do_reset();
      i_imem_gnt = 1'b1; i_ready = 1'b1; lat = 3;
      repeat (2) cycle();
      gi = gq.size();
      i_redirect = 1'b1; i_redirect_pc = 32'h200;
      cycle();
      i_redirect_pc = 32'h300;
      cycle();
      i_redirect = 1'b0;
      run_until_dq(1, 30, "b2b");
      if (dq_pc.size() < 1) return;
      asserts++; if (gq[gi] !== 32'h300) begin fails++; $display("FAIL b2b_addr: got %h expected 00000300", gq[gi]); end
      asserts++; if (dq_pc[0] !== 32'h300) begin fails++; $display("FAIL b2b_pc: got %h expected 00000300", dq_pc[0]); end
      asserts++; if (dq_inst[0] !== 32'hDEAD_0300) begin fails++; $display("FAIL b2b_inst: got %h expected dead0300", dq_inst[0]); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      i_imem_gnt = 1'b1; i_ready = 1'b0; lat = 1;
      repeat (8) cycle();
      asserts++; if (obs_valid !== 1'b1) begin fails++; $display("FAIL mrst_full: got %b expected 1", obs_valid); end
      i_rst = 1'b1;
      cycle();
      asserts++; if (obs_valid !== 1'b0) begin fails++; $display("FAIL mrst_valid: got %b expected 0", obs_valid); end
      asserts++; if (obs_inst !== NOP) begin fails++; $display("FAIL mrst_inst: got %h expected %h", obs_inst, NOP); end
      i_rst = 1'b0;
      i_ready = 1'b1;
      cycle();
      asserts++; if (obs_valid !== 1'b0) begin fails++; $display("FAIL mrst_post_valid: got %b expected 0", obs_valid); end
      asserts++; if (obs_inst !== NOP) begin fails++; $display("FAIL mrst_post_inst: got %h expected %h", obs_inst, NOP); end
      asserts++; if (obs_req !== 1'b1) begin fails++; $display("FAIL mrst_post_req: got %b expected 1", obs_req); end
      asserts++; if (obs_addr !== 32'h0) begin fails++; $display("FAIL mrst_post_addr: got %h expected 00000000", obs_addr); end
   endtask

   initial begin
      i_rst = 1'b1; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
      i_redirect = 1'b0; i_redirect_pc = 32'h0; i_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_stale();
      test_misaligned();
      test_wrap();
      test_back_to_back();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
